// File: rtl/dmem_store_buffer_if.sv
// Load/store port between the core and the store buffer, plus the handshaked
// backing-memory port. The store buffer itself uses the slave view.
interface dmem_store_buffer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // Core side
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              stall;
  logic              empty;
  logic              full;

  // Backing-memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr, rd, addr, wr_data, mem_ack, mem_rdata,
    output rd_data, stall, empty, full, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output wr, rd, addr, wr_data, mem_ack, mem_rdata,
    input  rd_data, stall, empty, full, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store FIFO between the core load/store port and a handshaked backing memory,
// with youngest-first store-to-load forwarding and a stalling read-miss path.
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               reset,
  dmem_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              empty, full, load, push, pop;
  logic              hit, stall, capture_rd;
  logic [DATA_W-1:0] hit_data, rd_data;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign load  = bus.rd && !bus.wr;          // a simultaneous store wins
  assign push  = bus.wr && !full;            // full sampled before any same-cycle pop
  assign pop   = (state == DRAIN) && bus.mem_ack;

  // Walk oldest to youngest so the last match left standing is the youngest.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && fifo_addr[head + PTR_W'(i)] == bus.addr) begin
        hit      = 1'b1;
        hit_data = fifo_data[head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    stall      = bus.wr && full;
    capture_rd = 1'b0;
    rd_data    = rd_data_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (load && !hit) begin
          stall      = 1'b1;
          capture_rd = 1'b1;
          state_nxt  = READ;
        end else begin
          if (load) rd_data = hit_data;
          if (!empty) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[head];
        mem_wdata = fifo_data[head];
        if (load) begin
          if (hit) rd_data = hit_data;
          else     stall   = 1'b1;
        end
        if (bus.mem_ack) state_nxt = IDLE;
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_q;
        stall    = 1'b1;
        if (bus.mem_ack) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (capture_rd) rd_addr_q <= bus.addr;
      if (state == READ && bus.mem_ack) rd_data_q <= bus.mem_rdata;
      else                              rd_data_q <= rd_data;
    end
  end

  // NOTE: the entry storage has no reset; an entry is only visible while the
  // count covers it, so clearing the pointers is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= bus.addr;
      fifo_data[tail] <= bus.wr_data;
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.stall     = stall;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed scenarios with a hand-driven memory, then random traffic against an
// architectural memory image and a program-order store log.
`timescale 1ns/1ps
module tb_dmem_store_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;
  localparam int MEM_N  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory side: hand-driven in directed tests, auto responder in random phase
  bit                auto_mem = 1'b0;
  logic              manual_ack = 1'b0;
  logic [DATA_W-1:0] manual_rdata = '0;
  logic              auto_ack = 1'b0;
  logic [DATA_W-1:0] auto_rdata = '0;
  int unsigned       wait_cnt = 0;
  logic [DATA_W-1:0] mem_img [MEM_N];
  bit                img_valid [MEM_N];
  wr_t               drained [$];

  assign bus.mem_ack   = auto_mem ? auto_ack   : manual_ack;
  assign bus.mem_rdata = auto_mem ? auto_rdata : manual_rdata;

  function automatic logic [DATA_W-1:0] init_pat(logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | DATA_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] mem_value(logic [ADDR_W-1:0] a);
    return img_valid[a] ? mem_img[a] : init_pat(a);
  endfunction

  always @(posedge clk) begin
    if (auto_mem && auto_ack && bus.mem_req && bus.mem_we) begin
      mem_img[bus.mem_addr]   <= bus.mem_wdata;
      img_valid[bus.mem_addr] <= 1'b1;
      drained.push_back({bus.mem_addr, bus.mem_wdata});
    end
    if (!auto_mem || !bus.mem_req || auto_ack) begin
      auto_ack <= 1'b0;
      wait_cnt <= $urandom_range(0, 3);
    end else if (wait_cnt == 0) begin
      auto_ack   <= 1'b1;
      auto_rdata <= mem_value(bus.mem_addr);
    end else begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  // Core-side architectural view for the random phase
  logic [DATA_W-1:0] shadow [MEM_N];
  bit                sh_valid [MEM_N];
  wr_t               exp_q [$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
  endtask

  task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr      = 1'b1;
    bus.rd      = 1'b0;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  task automatic drive_load(input logic [ADDR_W-1:0] a);
    bus.wr   = 1'b0;
    bus.rd   = 1'b1;
    bus.addr = a;
  endtask

  task automatic apply_reset();
    idle_inputs();
    manual_ack = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic drain_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      settle();
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) seen = 1'b1;
      else next_cycle();
    end
    check("drain_req_seen", seen, 1);
    if (seen) begin
      check("drain_addr", bus.mem_addr, a);
      check("drain_wdata", bus.mem_wdata, d);
      manual_ack = 1'b1;
      next_cycle();
      manual_ack = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit                acc;
    bit                done;
    int                level;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_d;

    // Reset state
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    reset = 1'b1;
    next_cycle();

    // Three stores, memory never acks: drain request held stable on the head
    drive_store(9'h010, 32'h11); settle(); check("t1_stall_a", bus.stall, 0); next_cycle();
    drive_store(9'h011, 32'h22); settle(); check("t1_stall_b", bus.stall, 0); next_cycle();
    drive_store(9'h012, 32'h33); settle(); check("t1_stall_c", bus.stall, 0); next_cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t1_empty", bus.empty, 0);
      check("t1_mem_req", bus.mem_req, 1);
      check("t1_mem_we", bus.mem_we, 1);
      check("t1_mem_addr", bus.mem_addr, 9'h010);
      check("t1_mem_wdata", bus.mem_wdata, 32'h11);
      next_cycle();
    end

    // Youngest of two stores to one address is forwarded
    apply_reset();
    drive_store(9'h020, 32'hAAAA); next_cycle();
    drive_store(9'h020, 32'hBBBB); next_cycle();
    drive_load(9'h020);
    settle();
    check("t2_fwd_data", bus.rd_data, 32'hBBBB);
    check("t2_fwd_stall", bus.stall, 0);
    check("t2_no_read", bus.mem_we, 1);
    next_cycle();
    bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 9'h021; bus.wr_data = 32'hC;
    settle();
    check("t2_wr_rd_stall", bus.stall, 0);
    check("t2_rd_data_hold", bus.rd_data, 32'hBBBB);
    next_cycle();
    idle_inputs();
    settle();
    check("t2_still_drain", bus.mem_we, 1);
    check("t2_head_addr", bus.mem_addr, 9'h020);
    check("t2_head_data", bus.mem_wdata, 32'hAAAA);
    next_cycle();

    // Fill, stall on the fifth store, one ack frees a slot, order preserved
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_store(ADDR_W'(i), DATA_W'(i));
      settle();
      check("t3_fill_stall", bus.stall, 0);
      next_cycle();
    end
    drive_store(9'h005, 32'h55);
    settle();
    check("t3_full", bus.full, 1);
    check("t3_full_stall", bus.stall, 1);
    check("t3_head_addr", bus.mem_addr, 9'h001);
    manual_ack = 1'b1;
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t3_not_full", bus.full, 0);
    check("t3_accept_stall", bus.stall, 0);
    next_cycle();
    idle_inputs();
    drain_one(9'h002, 32'h2);
    drain_one(9'h003, 32'h3);
    drain_one(9'h004, 32'h4);
    drain_one(9'h005, 32'h55);
    settle();
    check("t3_empty_after", bus.empty, 1);
    check("t3_req_after", bus.mem_req, 0);
    next_cycle();

    // Read miss on an empty buffer, ack on the third READ cycle
    apply_reset();
    drive_load(9'h100);
    settle();
    check("t4_miss_stall", bus.stall, 1);
    check("t4_no_req_yet", bus.mem_req, 0);
    next_cycle();
    settle();
    check("t4_rd_req", bus.mem_req, 1);
    check("t4_rd_we", bus.mem_we, 0);
    check("t4_rd_addr", bus.mem_addr, 9'h100);
    check("t4_stall_1", bus.stall, 1);
    next_cycle();
    settle();
    check("t4_stall_2", bus.stall, 1);
    check("t4_addr_stable", bus.mem_addr, 9'h100);
    next_cycle();
    manual_rdata = 32'hDEADBEEF;
    manual_ack   = 1'b1;
    settle();
    check("t4_stall_ack", bus.stall, 1);
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t4_resp_data", bus.rd_data, 32'hDEADBEEF);
    check("t4_resp_stall", bus.stall, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("t4_hold_data", bus.rd_data, 32'hDEADBEEF);
    check("t4_idle_req", bus.mem_req, 0);
    // A stray ack with no request outstanding changes nothing
    manual_ack = 1'b1;
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t5_stray_empty", bus.empty, 1);
    check("t5_stray_req", bus.mem_req, 0);
    next_cycle();

    // Miss during an outstanding drain: the drain completes first
    apply_reset();
    drive_store(9'h030, 32'h77); next_cycle();
    idle_inputs(); next_cycle();
    drive_load(9'h040);
    settle();
    check("t6_stall_drain", bus.stall, 1);
    check("t6_drain_we", bus.mem_we, 1);
    check("t6_drain_addr", bus.mem_addr, 9'h030);
    check("t6_drain_data", bus.mem_wdata, 32'h77);
    next_cycle();
    settle();
    check("t6_drain_hold", bus.mem_addr, 9'h030);
    check("t6_stall_hold", bus.stall, 1);
    manual_ack = 1'b1;
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t6_gap_stall", bus.stall, 1);
    check("t6_gap_req", bus.mem_req, 0);
    check("t6_gap_empty", bus.empty, 1);
    next_cycle();
    settle();
    check("t6_rd_req", bus.mem_req, 1);
    check("t6_rd_we", bus.mem_we, 0);
    check("t6_rd_addr", bus.mem_addr, 9'h040);
    manual_rdata = 32'h1234;
    manual_ack   = 1'b1;
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t6_resp_data", bus.rd_data, 32'h1234);
    check("t6_resp_stall", bus.stall, 0);
    next_cycle();
    idle_inputs();

    // Reset in the middle of a READ discards buffered stores
    apply_reset();
    drive_store(9'h050, 32'h5A); next_cycle();
    drive_load(9'h060);
    settle();
    check("t7_miss_stall", bus.stall, 1);
    next_cycle();
    settle();
    check("t7_in_read", bus.mem_req, 1);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("t7_rst_req", bus.mem_req, 0);
    check("t7_rst_stall", bus.stall, 0);
    check("t7_rst_empty", bus.empty, 1);
    check("t7_rst_rd_data", bus.rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    drive_load(9'h050);
    settle();
    check("t7_no_stale_hit", bus.stall, 1);
    next_cycle();
    settle();
    check("t7_rd_req", bus.mem_req, 1);
    check("t7_rd_we", bus.mem_we, 0);
    check("t7_rd_addr", bus.mem_addr, 9'h050);
    manual_rdata = 32'hCAFE;
    manual_ack   = 1'b1;
    next_cycle();
    manual_ack = 1'b0;
    settle();
    check("t7_resp_data", bus.rd_data, 32'hCAFE);
    next_cycle();
    idle_inputs();

    // Random traffic: loads must see the latest store in program order
    apply_reset();
    auto_mem = 1'b1;
    for (int op = 0; op < 250; op++) begin
      a = ADDR_W'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[ADDR_W-1] = 1'b1;
      if ($urandom_range(0, 9) < 6) begin
        d = $urandom;
        drive_store(a, d);
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
          settle();
          level = exp_q.size() - drained.size();
          check("rnd_full", bus.full, (level == DEPTH));
          check("rnd_empty", bus.empty, (level == 0));
          check("rnd_store_stall", bus.stall, (level == DEPTH));
          if (bus.stall === 1'b0) acc = 1'b1;
          next_cycle();
        end
        check("rnd_store_accepted", acc, 1);
        if (acc) begin
          shadow[a]   = d;
          sh_valid[a] = 1'b1;
          exp_q.push_back({a, d});
        end
      end else begin
        drive_load(a);
        exp_d = sh_valid[a] ? shadow[a] : init_pat(a);
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
          settle();
          if (bus.stall === 1'b0) begin
            acc = 1'b1;
            check("rnd_load_data", bus.rd_data, exp_d);
          end
          next_cycle();
        end
        check("rnd_load_served", acc, 1);
      end
      idle_inputs();
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    // Flush and compare the drained write stream with program order
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      settle();
      if (bus.empty === 1'b1 && bus.mem_req === 1'b0) done = 1'b1;
      else next_cycle();
    end
    check("rnd_flush_done", done, 1);
    check("rnd_drain_count", drained.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
      check("rnd_drain_order", drained[i], exp_q[i]);
    auto_mem = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory-side stage directly downstream of the core's load/store port (wr, rd, addr, wr_data, rd_data).
- Decouples single-cycle core stores from a slower handshaked backing memory via a small store FIFO, with store-to-load forwarding.
- A read miss stalls the core until the backing memory answers.
- Ordering preserved: stores drain in program order; loads observe the youngest buffered store to the same address.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, word address width (full-width equality compare)
DEPTH, 4, store FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
wr  input  1  core store request
rd  input  1  core load request
addr  input  ADDR_W  core address
wr_data  input  DATA_W  core store data
rd_data  output  DATA_W  load data to core
stall  output  1  core must hold its current request
mem_req  output  1  backing-memory request valid
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  backing-memory address
mem_wdata  output  DATA_W  backing-memory write data
mem_ack  input  1  backing memory accepts/completes request (single cycle)
mem_rdata  input  DATA_W  read data, valid with mem_ack when mem_we=0
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries

Behaviour:
- Reset (reset=0, async): FIFO cleared, pointers/count 0, state IDLE. rd_data=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1, full=0. Reset mid-operation discards buffered stores; mem_req drops immediately.
- FSM states: IDLE, DRAIN, READ, RESP.
- Store: wr=1 and full=0 -> enqueue {addr,wr_data} at clock edge, stall=0. wr=1 and full=1 -> stall=1, nothing enqueued. full is evaluated before any same-cycle pop (conservative).
- wr and rd both high: treated as store only; rd ignored that cycle.
- Load forwarding: rd=1 -> combinationally search valid entries youngest-first for addr match.
  - Hit: rd_data = matching entry data, stall=0, same cycle, no memory access.
  - An entry being popped that same cycle still forwards.
- Load miss, state IDLE: stall=1. Next state READ with mem_req=1, mem_we=0, mem_addr=addr. A miss takes priority over a drain start.
- Load miss, state DRAIN: stall=1 until the drain completes, then the read issues.
- READ: hold mem_req/mem_addr stable until mem_ack. On mem_ack, capture mem_rdata and go to RESP; stall stays 1.
- RESP (one cycle): rd_data = captured data, stall=0, then IDLE.
- Miss latency: data is delivered the cycle after mem_ack.
- Drain: in IDLE with empty=0 and no load miss -> DRAIN.
  - Drives mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry, all held stable until mem_ack.
  - On mem_ack, pop head and return to IDLE.
  - Minimum 2 cycles per drained entry.
- Stores are accepted in any state while not full, including DRAIN and READ. The core is normally stalled during READ.
- Pointers wrap modulo DEPTH. Count range 0..DEPTH; a simultaneous push and pop leaves count unchanged.
- mem_ack while mem_req=0 is ignored.
- rd_data holds its last value when no load is served.

Test Plan:
- Reset, then 3 stores (A=0x010:0x11, 0x011:0x22, 0x012:0x33) with mem_ack tied 0 -> no stall, empty=0, mem_req=1/mem_we=1/mem_addr=0x010 held stable.
- Two stores to 0x020 (0xAAAA then 0xBBBB), then load 0x020 -> rd_data=0xBBBB same cycle, stall=0, no read request issued.
- 4 stores with mem_ack=0, 5th store 0x005:0x55 -> full=1, stall=1. Pulse one mem_ack -> head popped, then the 5th store enqueues; stores drain to memory in original order.
- Empty buffer, load 0x100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> stall=1 through the ack cycle, RESP cycle shows rd_data=0xDEADBEEF with stall=0.
- Load miss issued while a drain is outstanding -> read issues only after the drain ack; drain data 0x77 reaches 0x030 first.
- Reset asserted mid-READ -> mem_req=0, stall=0, empty=1 immediately; after release, a load to a previously buffered address goes to memory (no stale hit).
